// File: rtl/busy_window_gen.sv
// busy_window_gen: turns start pulses into back-to-back windows of BUSY_LEN busy cycles, queuing up to MAX_PENDING starts
module busy_window_gen #(
  parameter int BUSY_LEN = 5,
  parameter int MAX_PENDING = 3,
  localparam int CW = $clog2(BUSY_LEN + 1),
  localparam int PW = $clog2(MAX_PENDING + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          ready,
  output logic          busy,
  output logic          done,
  output logic [PW-1:0] pending,
  output logic          overflow
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic [PW-1:0] r_pending, w_pending_nx;
  logic r_overflow;
  logic w_accept, w_last, w_inc, w_dec;
  assign ready = r_pending < PW'(MAX_PENDING);
  assign w_accept = start && ready;
  assign w_last = r_cnt == '0;
  // a start landing on the last cycle with nothing queued reloads the window directly
  assign w_inc = w_accept && !(w_last && r_pending == '0);
  assign w_dec = w_last && r_pending != '0;
  assign busy = r_state == BUSY;
  assign done = busy && w_last;
  assign pending = r_pending;
  assign overflow = r_overflow;
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx = r_cnt;
    w_pending_nx = r_pending;
    if (r_state == IDLE) begin
      w_state_nx = w_accept ? BUSY : IDLE;
      w_cnt_nx = w_accept ? CW'(BUSY_LEN - 1) : '0;
    end else begin
      w_state_nx = (w_last && r_pending == '0 && !w_accept) ? IDLE : BUSY;
      w_cnt_nx = w_last ? ((w_state_nx == IDLE) ? '0 : CW'(BUSY_LEN - 1)) : r_cnt - 1'b1;
      w_pending_nx = r_pending + PW'(w_inc) - PW'(w_dec);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_pending <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt <= w_cnt_nx;
      r_pending <= w_pending_nx;
      r_overflow <= r_overflow || (start && !ready);
    end
  end
endmodule

// File: tb/tb_busy_window_gen.sv
// tb_busy_window_gen: checks two configurations (5/3 and 1/1) against a model that tracks total owed busy cycles
module tb_busy_window_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic rdy0, busy0, done0, ovf0;
  logic [1:0] pend0;
  logic rdy1, busy1, done1, ovf1;
  logic pend1;
  int n_chk = 0;
  int n_pass = 0;
  int owed[2];
  bit m_ovf[2];
  int len[2] = '{5, 1};
  int maxp[2] = '{3, 1};

  always #5 clk = ~clk;

  busy_window_gen #(.BUSY_LEN(5), .MAX_PENDING(3)) u0 (
    .clk(clk), .rst(rst), .start(start), .ready(rdy0), .busy(busy0),
    .done(done0), .pending(pend0), .overflow(ovf0));
  busy_window_gen #(.BUSY_LEN(1), .MAX_PENDING(1)) u1 (
    .clk(clk), .rst(rst), .start(start), .ready(rdy1), .busy(busy1),
    .done(done1), .pending(pend1), .overflow(ovf1));

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
  endtask

  function automatic int m_pend(input int i);
    return owed[i] > 0 ? (owed[i] - 1) / len[i] : 0;
  endfunction

  task automatic check_outputs();
    for (int i = 0; i < 2; i++) begin
      int p = m_pend(i);
      bit b = owed[i] > 0;
      chk($sformatf("busy%0d", i), i == 0 ? int'(busy0) : int'(busy1), int'(b));
      chk($sformatf("done%0d", i), i == 0 ? int'(done0) : int'(done1),
          int'(b && (owed[i] - 1) % len[i] == 0));
      chk($sformatf("pending%0d", i), i == 0 ? int'(pend0) : int'(pend1), p);
      chk($sformatf("ready%0d", i), i == 0 ? int'(rdy0) : int'(rdy1), int'(p < maxp[i]));
      chk($sformatf("overflow%0d", i), i == 0 ? int'(ovf0) : int'(ovf1), int'(m_ovf[i]));
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      owed[i] = 0;
      m_ovf[i] = 0;
    end
  endtask

  task automatic step(input bit s);
    check_outputs();
    for (int i = 0; i < 2; i++) begin
      bit r = m_pend(i) < maxp[i];
      if (s && !r) m_ovf[i] = 1;
      owed[i] = (owed[i] > 0 ? owed[i] - 1 : 0) + ((s && r) ? len[i] : 0);
    end
    start = s;
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst = 1'b0;
    @(negedge clk);
    // single window, then back-to-back, then a full queue with one dropped start
    step(1);
    repeat (7) step(0);
    step(1);
    repeat (4) step(0);
    step(1);
    repeat (7) step(0);
    repeat (4) step(1);
    step(1);
    repeat (24) step(0);
    // reset in the middle of a window
    step(1);
    step(0);
    step(0);
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_busy0", int'(busy0), 0);
    chk("rst_busy1", int'(busy1), 0);
    chk("rst_done0", int'(done0), 0);
    chk("rst_pend0", int'(pend0), 0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    check_outputs();
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    step(1);
    repeat (6) step(0);
    for (int ph = 0; ph < 8; ph++) begin
      int dens = (ph % 4 == 0) ? 10 : (ph % 4 == 1) ? 30 : (ph % 4 == 2) ? 60 : 90;
      for (int k = 0; k < 500; k++) step($urandom_range(99) < dens);
    end
    repeat (10) step(0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
